// File: rtl/forbid_mon_pkg.sv
// Shared limits and types for the forbidden-sequence monitor.
package forbid_mon_pkg;
    localparam int MAX_DLY_LIMIT = 16;
    localparam int NUM_CH_LIMIT  = 32;
    localparam int TS_W          = 16;

    typedef logic [TS_W-1:0] ts_t;
endpackage

// File: rtl/forbid_ch_det.sv
// One monitored channel: antecedent history shift register plus window match.
module forbid_ch_det #(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic p,
    input  logic q,
    output logic match
);
    // hist[k] holds p as seen k cycles ago; a disabled cycle records a zero.
    logic [MAX_DLY:1] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (clr) begin
            hist <= '0;
        end else begin
            hist[1] <= en & p;
            for (int k = 2; k <= MAX_DLY; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    assign match = en & q & (|hist[MAX_DLY:MIN_DLY]);
endmodule

// File: rtl/forbid_seq_monitor.sv
// Multi-channel monitor flagging q within [MIN_DLY:MAX_DLY] cycles after p.
// Optional FORBID_MON_TSTAMP_EN adds a cycle counter and a first_time output.
module forbid_seq_monitor
    import forbid_mon_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 1,
    parameter int CNT_W   = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        en,
    input  logic                                        clr,
    input  logic [NUM_CH-1:0]                           p,
    input  logic [NUM_CH-1:0]                           q,
    output logic [NUM_CH-1:0]                           viol,
    output logic [NUM_CH-1:0]                           viol_sticky,
    output logic [CNT_W-1:0]                            viol_cnt,
    output logic                                        first_vld,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_ch
`ifdef FORBID_MON_TSTAMP_EN
    ,
    output ts_t                                         first_time
`endif
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PC_W = 6;

    if (MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > MAX_DLY_LIMIT ||
        NUM_CH < 1 || NUM_CH > NUM_CH_LIMIT) begin : g_bad_cfg
        $error("forbid_seq_monitor: illegal NUM_CH/MIN_DLY/MAX_DLY");
    end

    logic [NUM_CH-1:0] match;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        forbid_ch_det #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY)
        ) u_det (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .clr   (clr),
            .p     (p[c]),
            .q     (q[c]),
            .match (match[c])
        );
    end

    logic [PC_W-1:0]       match_cnt;
    logic [CH_W-1:0]       low_ch;
    logic [CNT_W+PC_W-1:0] cnt_sum;
    logic [CNT_W-1:0]      cnt_next;

    // Walk downward so the lowest matching index is the one left in low_ch.
    always_comb begin
        match_cnt = '0;
        low_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (match[i]) begin
                match_cnt = match_cnt + 1'b1;
                low_ch    = CH_W'(i);
            end
        end
        cnt_sum = {{PC_W{1'b0}}, viol_cnt} + {{CNT_W{1'b0}}, match_cnt};
        if (cnt_sum > {{PC_W{1'b0}}, {CNT_W{1'b1}}}) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

`ifdef FORBID_MON_TSTAMP_EN
    ts_t ts_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_time <= '0;
        end else if (clr) begin
            first_time <= '0;
        end else if (!first_vld && (|match)) begin
            first_time <= ts_cnt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol        <= '0;
            viol_sticky <= '0;
            viol_cnt    <= '0;
            first_vld   <= 1'b0;
            first_ch    <= '0;
        end else if (clr) begin
            viol        <= '0;
            viol_sticky <= '0;
            viol_cnt    <= '0;
            first_vld   <= 1'b0;
            first_ch    <= '0;
        end else begin
            viol        <= match;
            viol_sticky <= viol_sticky | match;
            viol_cnt    <= cnt_next;
            if (!first_vld && (|match)) begin
                first_vld <= 1'b1;
                first_ch  <= low_ch;
            end
        end
    end
endmodule

// File: tb/tb_forbid_seq_monitor.sv
// Bench for forbid_seq_monitor: directed scenarios on three configurations plus
// a randomized run against a cycle-timestamp reference model.
module tb_forbid_seq_monitor;
    logic clk;
    logic rst_n;

    // single channel, window [1,1]
    logic       s_en, s_clr;
    logic [0:0] s_p, s_q, s_viol, s_sticky, s_fch;
    logic [7:0] s_cnt;
    logic       s_fvld;
    // four channels, window [2,4], 2-bit counter
    logic       w_en, w_clr;
    logic [3:0] w_p, w_q, w_viol, w_sticky;
    logic [1:0] w_cnt, w_fch;
    logic       w_fvld;
    // four channels, window [2,5], randomized
    logic       r_en, r_clr;
    logic [3:0] r_p, r_q, r_viol, r_sticky;
    logic [7:0] r_cnt;
    logic [1:0] r_fch;
    logic       r_fvld;
`ifdef FORBID_MON_TSTAMP_EN
    logic [15:0] s_ftime, w_ftime, r_ftime;
`endif

    int ncmp = 0;
    int nerr = 0;

    forbid_seq_monitor #(.NUM_CH(1), .MIN_DLY(1), .MAX_DLY(1), .CNT_W(8)) u_single (
        .clk(clk), .rst_n(rst_n), .en(s_en), .clr(s_clr), .p(s_p), .q(s_q),
        .viol(s_viol), .viol_sticky(s_sticky), .viol_cnt(s_cnt),
        .first_vld(s_fvld), .first_ch(s_fch)
`ifdef FORBID_MON_TSTAMP_EN
        , .first_time(s_ftime)
`endif
    );

    forbid_seq_monitor #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(2)) u_win (
        .clk(clk), .rst_n(rst_n), .en(w_en), .clr(w_clr), .p(w_p), .q(w_q),
        .viol(w_viol), .viol_sticky(w_sticky), .viol_cnt(w_cnt),
        .first_vld(w_fvld), .first_ch(w_fch)
`ifdef FORBID_MON_TSTAMP_EN
        , .first_time(w_ftime)
`endif
    );

    forbid_seq_monitor #(.NUM_CH(4), .MIN_DLY(2), .MAX_DLY(5), .CNT_W(8)) u_rand (
        .clk(clk), .rst_n(rst_n), .en(r_en), .clr(r_clr), .p(r_p), .q(r_q),
        .viol(r_viol), .viol_sticky(r_sticky), .viol_cnt(r_cnt),
        .first_vld(r_fvld), .first_ch(r_fch)
`ifdef FORBID_MON_TSTAMP_EN
        , .first_time(r_ftime)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_en = 1'b1; s_clr = 1'b0; s_p = '0; s_q = '0;
        w_en = 1'b1; w_clr = 1'b0; w_p = '0; w_q = '0;
        r_en = 1'b1; r_clr = 1'b0; r_p = '0; r_q = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_en = 1'b1; s_p = '1; s_q = '1; s_clr = 1'b0;
        w_en = 1'b1; w_p = '1; w_q = '1; w_clr = 1'b0;
        r_en = 1'b1; r_p = '1; r_q = '1; r_clr = 1'b0;
        tick(); tick();
        ncmp++;
        if ({s_viol, s_sticky, s_cnt, s_fvld, s_fch} !== '0) begin
            nerr++; $display("FAIL reset_single: got %h want 0", {s_viol, s_sticky, s_cnt, s_fvld, s_fch});
        end
        ncmp++;
        if ({w_viol, w_sticky, w_cnt, w_fvld, w_fch} !== '0) begin
            nerr++; $display("FAIL reset_win: got %h want 0", {w_viol, w_sticky, w_cnt, w_fvld, w_fch});
        end
        ncmp++;
        if ({r_viol, r_sticky, r_cnt, r_fvld, r_fch} !== '0) begin
            nerr++; $display("FAIL reset_rand: got %h want 0", {r_viol, r_sticky, r_cnt, r_fvld, r_fch});
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        // p held during reset must not create a match now
        s_q = '1;
        tick();
        s_q = '0;
        ncmp++;
        if (s_viol !== 1'b0) begin
            nerr++; $display("FAIL reset_no_pending: got %b want 0", s_viol);
        end
    endtask

    task automatic test_single();
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        s_p = 1'b1; s_q = 1'b0; tick();
        ncmp++;
        if (s_viol !== 1'b0) begin nerr++; $display("FAIL single_t1: viol got %b want 0", s_viol); end
        s_p = 1'b0; s_q = 1'b1; tick();
        ncmp++;
        if (s_viol !== 1'b1) begin nerr++; $display("FAIL single_viol: got %b want 1", s_viol); end
        ncmp++;
        if (s_cnt !== 8'd1) begin nerr++; $display("FAIL single_cnt: got %0d want 1", s_cnt); end
        ncmp++;
        if ({s_fvld, s_fch} !== 2'b10) begin nerr++; $display("FAIL single_first: got %b want 10", {s_fvld, s_fch}); end
        s_q = 1'b0; tick();
        ncmp++;
        if ({s_viol, s_sticky} !== 2'b01) begin nerr++; $display("FAIL single_pulse: viol,sticky got %b want 01", {s_viol, s_sticky}); end
    endtask

    task automatic test_window();
        w_clr = 1'b1; tick(); w_clr = 1'b0;
        w_p = 4'b0001; tick(); w_p = '0;          // t0
        w_q = 4'b0001; tick();                      // t1, distance 1
        ncmp++;
        if (w_viol !== 4'b0000) begin nerr++; $display("FAIL window_d1: got %b want 0000", w_viol); end
        w_q = '0; tick();                           // t2
        w_q = 4'b0001; tick();                      // t3, distance 3
        ncmp++;
        if (w_viol !== 4'b0001) begin nerr++; $display("FAIL window_d3: got %b want 0001", w_viol); end
        w_q = '0; tick();                           // t4
        w_q = 4'b0001; tick();                      // t5, distance 5
        w_q = '0;
        ncmp++;
        if (w_viol !== 4'b0000) begin nerr++; $display("FAIL window_d5: got %b want 0000", w_viol); end
        ncmp++;
        if ({w_cnt, w_fvld, w_fch} !== 5'b01_1_00) begin
            nerr++; $display("FAIL window_status: got %b want 01100", {w_cnt, w_fvld, w_fch});
        end
    endtask

    task automatic test_simultaneous();
        w_clr = 1'b1; tick(); w_clr = 1'b0;
        w_p = 4'b1010; tick(); w_p = '0;
        tick();
        w_q = 4'b1010; tick(); w_q = '0;
        ncmp++;
        if (w_viol !== 4'b1010) begin nerr++; $display("FAIL simul_viol: got %b want 1010", w_viol); end
        ncmp++;
        if (w_cnt !== 2'd2) begin nerr++; $display("FAIL simul_cnt: got %0d want 2", w_cnt); end
        ncmp++;
        if ({w_fvld, w_fch} !== 3'b101) begin nerr++; $display("FAIL simul_first: got %b want 101", {w_fvld, w_fch}); end
    endtask

    task automatic test_saturate_clr();
        w_clr = 1'b1; tick(); w_clr = 1'b0;
        w_p = 4'b0001; w_q = 4'b0001;
        for (int i = 0; i < 7; i++) tick();         // matches in cycles 2..6
        ncmp++;
        if (w_cnt !== 2'd3) begin nerr++; $display("FAIL sat_cnt: got %0d want 3", w_cnt); end
        tick();
        ncmp++;
        if ({w_viol, w_cnt} !== 6'b0001_11) begin nerr++; $display("FAIL sat_hold: got %b want 000111", {w_viol, w_cnt}); end
        w_clr = 1'b1; tick(); w_clr = 1'b0;
        ncmp++;
        if ({w_viol, w_sticky, w_cnt, w_fvld, w_fch} !== '0) begin
            nerr++; $display("FAIL clr_status: got %b want 0", {w_viol, w_sticky, w_cnt, w_fvld, w_fch});
        end
        tick(); tick();
        ncmp++;
        if (w_viol !== 4'b0000) begin nerr++; $display("FAIL clr_history: got %b want 0000", w_viol); end
        tick();
        ncmp++;
        if (w_viol !== 4'b0001) begin nerr++; $display("FAIL clr_recover: got %b want 0001", w_viol); end
        w_p = '0; w_q = '0;
        tick();
    endtask

    task automatic test_enable();
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        s_en = 1'b0; s_p = 1'b1; tick();
        s_en = 1'b1; s_p = 1'b0; s_q = 1'b1; tick(); s_q = 1'b0;
        ncmp++;
        if ({s_viol, s_cnt} !== '0) begin nerr++; $display("FAIL enable_gap: got %b want 0", {s_viol, s_cnt}); end
    endtask

    task automatic test_reset_mid();
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        s_p = 1'b1; s_q = 1'b1; tick(); tick();       // builds sticky state
        s_q = 1'b0; tick(); s_p = 1'b0;
        rst_n = 1'b0; #2;
        ncmp++;
        if ({s_viol, s_sticky, s_cnt, s_fvld, s_fch} !== '0) begin
            nerr++; $display("FAIL rst_async: got %h want 0", {s_viol, s_sticky, s_cnt, s_fvld, s_fch});
        end
        rst_n = 1'b1;
        s_q = 1'b1; tick(); s_q = 1'b0;
        ncmp++;
        if ({s_viol, s_sticky, s_cnt, s_fvld, s_fch} !== '0) begin
            nerr++; $display("FAIL rst_mid_window: got %h want 0", {s_viol, s_sticky, s_cnt, s_fvld, s_fch});
        end
    endtask

`ifdef FORBID_MON_TSTAMP_EN
    task automatic test_tstamp();
        idle_inputs();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();           // cycles 0..7
        s_p = 1'b1; tick(); s_p = 1'b0;               // cycle 8
        s_q = 1'b1; tick(); s_q = 1'b0;               // cycle 9 = 10th cycle
        ncmp++;
        if (s_ftime !== 16'd9) begin nerr++; $display("FAIL tstamp_first: got %0d want 9", s_ftime); end
        s_p = 1'b1; tick(); s_p = 1'b0;
        s_q = 1'b1; tick(); s_q = 1'b0;
        ncmp++;
        if ({s_viol, s_ftime} !== {1'b1, 16'd9}) begin
            nerr++; $display("FAIL tstamp_hold: viol,time got %b,%0d want 1,9", s_viol, s_ftime);
        end
    endtask
`endif

    // scoreboard: cycle-indexed p log; a q in cycle t violates if p was seen
    // (while enabled, since the last reset/clr) at any cycle t-MAX..t-MIN.
    task automatic test_random();
        localparam int RMIN = 2;
        localparam int RMAX = 5;
        logic [3:0] plog [0:1023];
        logic [3:0] e_viol, e_sticky;
        logic [1:0] e_fch;
        logic       e_fvld;
        int         e_cnt;
        int         epoch;
        idle_inputs();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        e_viol = '0; e_sticky = '0; e_fch = '0; e_fvld = 1'b0; e_cnt = 0; epoch = 0;
        for (int t = 0; t < 800; t++) begin
            logic [3:0] m;
            r_en  = ($urandom_range(0, 9) != 0);
            r_clr = ($urandom_range(0, 79) == 0);
            r_p   = 4'($urandom & $urandom);
            r_q   = 4'($urandom & $urandom);
            m = '0;
            for (int c = 0; c < 4; c++)
                for (int k = RMIN; k <= RMAX; k++)
                    if (r_en && !r_clr && r_q[c] && (t - k) >= epoch && plog[t-k][c]) m[c] = 1'b1;
            plog[t] = (r_en && !r_clr) ? r_p : 4'b0000;
            if (r_clr) begin
                e_viol = '0; e_sticky = '0; e_cnt = 0; e_fvld = 1'b0; e_fch = '0;
                epoch = t + 1;
            end else begin
                e_viol = m;
                e_sticky = e_sticky | m;
                e_cnt = e_cnt + $countones(m);
                if (e_cnt > 255) e_cnt = 255;
                if (!e_fvld && m != 0) begin
                    e_fvld = 1'b1;
                    for (int c = 3; c >= 0; c--) if (m[c]) e_fch = 2'(c);
                end
            end
            tick();
            ncmp++;
            if (r_viol !== e_viol) begin nerr++; $display("FAIL rand_viol t=%0d: got %b want %b", t, r_viol, e_viol); end
            ncmp++;
            if (r_sticky !== e_sticky) begin nerr++; $display("FAIL rand_sticky t=%0d: got %b want %b", t, r_sticky, e_sticky); end
            ncmp++;
            if (r_cnt !== 8'(e_cnt)) begin nerr++; $display("FAIL rand_cnt t=%0d: got %0d want %0d", t, r_cnt, e_cnt); end
            ncmp++;
            if ({r_fvld, r_fch} !== {e_fvld, e_fch}) begin
                nerr++; $display("FAIL rand_first t=%0d: got %b want %b", t, {r_fvld, r_fch}, {e_fvld, e_fch});
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_window();
        test_simultaneous();
        test_saturate_clr();
        test_enable();
        test_reset_mid();
`ifdef FORBID_MON_TSTAMP_EN
        test_tstamp();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/forbid_seq_monitor.md
FORBID_SEQ_MONITOR -- requirements
Module: forbid_seq_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent monitored channels (1..32).
REQ-002 SHALL have parameter MIN_DLY, default 1, minimum p-to-q distance in cycles that is forbidden (>=1).
REQ-003 SHALL have parameter MAX_DLY, default 1, maximum forbidden p-to-q distance (MIN_DLY..16).
REQ-004 SHALL have parameter CNT_W, default 8, violation counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  monitor enable.
REQ-008 SHALL have port clr  input  1  synchronous clear of status and history.
REQ-009 SHALL have port p  input  NUM_CH  per-channel antecedent.
REQ-010 SHALL have port q  input  NUM_CH  per-channel consequent.
REQ-011 SHALL have port viol  output  NUM_CH  registered one-cycle violation pulse.
REQ-012 SHALL have port viol_sticky  output  NUM_CH  per-channel sticky flag.
REQ-013 SHALL have port viol_cnt  output  CNT_W  total saturating violation count.
REQ-014 SHALL have port first_vld  output  1  first violation captured.
REQ-015 SHALL have port first_ch  output  max(1,$clog2(NUM_CH))  channel of first violation.

Function
REQ-016 SHALL keep per channel a history hist[1..MAX_DLY], hist[k] = p sampled k cycles earlier; shifts each cycle en=1.
REQ-017 SHALL detect a match on channel c in cycle t when en=1, q[c]=1, and any hist[k]=1 for MIN_DLY<=k<=MAX_DLY (i.e. not (p ##[MIN_DLY:MAX_DLY] q)).
REQ-018 SHALL assert viol[c] in cycle t+1 for exactly one cycle per matching q cycle; several p in window yield one violation.
REQ-019 SHALL evaluate every q cycle independently: p at t0, q at t0+1 and t0+2 with window [1,2] gives two pulses.
REQ-020 SHALL, when en=0, shift zeros into history and report no matches; p seen while disabled never matches later.
REQ-021 SHALL set viol_sticky[c] with viol[c]; holds until clr or reset.
REQ-022 SHALL add popcount of matching channels to viol_cnt each cycle, saturating at 2^CNT_W-1.
REQ-023 SHALL, on first match after reset/clr, set first_vld and latch lowest-index matching channel into first_ch; later matches ignored.
REQ-024 SHALL give clr priority: in a clr cycle history, sticky, count, first_vld, first_ch clear, matches that cycle are discarded, viol is 0 next cycle.
REQ-025 SHALL fail elaboration if MIN_DLY<1, MAX_DLY<MIN_DLY, MAX_DLY>16, or NUM_CH outside 1..32.

Reset
REQ-026 SHALL on rst_n=0 asynchronously clear history, viol, viol_sticky, viol_cnt, first_vld, first_ch (all 0).
REQ-027 SHALL treat reset mid-window as discarding pending antecedents; first match needs a fresh p after release.

Configuration
REQ-028 SHALL, with FORBID_MON_TSTAMP_EN defined, add free-running 16-bit cycle counter (reset 0, wraps) and output first_time[15:0] latching counter value of the match cycle with first_ch.
REQ-029 SHALL, without FORBID_MON_TSTAMP_EN, have no counter and no first_time port.

Structure
REQ-030 SHALL place MAX_DLY_LIMIT=16, NUM_CH_LIMIT=32, timestamp width 16, and typedef ts_t in package forbid_mon_pkg.
REQ-031 SHALL instantiate per channel sub-module forbid_ch_det (history + match); aggregation, count, first-capture in top.

Verification
REQ-032 SHALL cover NUM_CH=1, MIN=MAX=1: p=1,q=0 at t0; q=1 at t1 -> viol=1 at t2, viol_cnt=1, first_ch=0.
REQ-033 SHALL cover window [2,4]: p at t0, q at t1 -> no viol; q at t3 -> viol at t4; q at t5 -> no viol.
REQ-034 SHALL cover NUM_CH=4: channels 1 and 3 match same cycle -> viol=4'b1010, viol_cnt+=2, first_ch=1.
REQ-035 SHALL cover CNT_W=2: five violations -> viol_cnt=3 held; clr with simultaneous match -> all status 0, viol=0 next cycle.
REQ-036 SHALL cover en=0 during p, en=1 before q -> no viol; rst_n low between p and q -> no viol, all outputs 0.
REQ-037 SHALL cover FORBID_MON_TSTAMP_EN: first match in 10th cycle after reset -> first_time=9; second match leaves it unchanged.
